// File: rtl/reg_file_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_file_wb                                                     |
// | Function : 32x32 integer register file with pending scoreboard, hazard     |
// |            stall, and an optional write-to-read bypass (REGFILE_BYPASS_EN).|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module reg_file_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_req,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] src1_value,
  output logic [DATA_WIDTH-1:0] src2_value,
  output logic                  read_valid,
  output logic                  hazard
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

`ifdef REGFILE_BYPASS_EN
  localparam logic c_bypass_en = 1'b1;
`else
  localparam logic c_bypass_en = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_d;
  logic [DATA_WIDTH-1:0] src1_q;
  logic [DATA_WIDTH-1:0] src2_q;
  logic                  read_valid_q;

  logic                  w_wr_en;
  logic                  w_rd_fire;
  logic [ADDR_WIDTH-1:0] w_rs_addr [2];
  logic [DATA_WIDTH-1:0] w_rs_val  [2];
  logic [1:0]            w_rs_pend;

  assign w_wr_en      = write_req && (write_addr != '0);
  assign w_rs_addr[0] = rs1_addr;
  assign w_rs_addr[1] = rs2_addr;

  // A forwarded write both supplies the operand and retires the pending producer.
  for (genvar p = 0; p < 2; p++) begin : g_src_port
    logic w_fwd;
    assign w_fwd        = c_bypass_en && write_req && (write_addr == w_rs_addr[p]);
    assign w_rs_val[p]  = (w_rs_addr[p] == '0) ? '0 :
                          w_fwd                ? write_data :
                                                 regs_q[w_rs_addr[p]];
    assign w_rs_pend[p] = (w_rs_addr[p] != '0) && pending_q[w_rs_addr[p]] && !w_fwd;
  end

  assign hazard    = read_en && (|w_rs_pend);
  assign w_rd_fire = read_en && !hazard;

  // Issue is applied after write-back so a same-cycle new producer keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    if (w_wr_en) begin
      pending_d[write_addr] = 1'b0;
    end
    if (flush) begin
      pending_d = '0;
    end else if (issue_en && (issue_rd != '0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q    <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      read_valid_q <= 1'b0;
    end else begin
      if (w_wr_en) begin
        regs_q[write_addr] <= write_data;
      end
      pending_q    <= pending_d;
      read_valid_q <= w_rd_fire;
      if (w_rd_fire) begin
        src1_q <= w_rs_val[0];
        src2_q <= w_rs_val[1];
      end
    end
  end

  assign src1_value = src1_q;
  assign src2_value = src2_q;
  assign read_valid = read_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_reg_file_wb                                                  |
// | Function : Scenario tests plus scoreboard-backed reference model for       |
// |            reg_file_wb; follows REGFILE_BYPASS_EN like the design.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_reg_file_wb;

`ifdef REGFILE_BYPASS_EN
  localparam logic TB_BYP = 1'b1;
`else
  localparam logic TB_BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        write_req;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        read_en;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [31:0] src1_value;
  logic [31:0] src2_value;
  logic        read_valid;
  logic        hazard;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
    .src1_value(src1_value), .src2_value(src2_value),
    .read_valid(read_valid), .hazard(hazard)
  );

  always #5 clk = ~clk;

  // Reference model state and scoreboard of expected {src1, src2}
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  logic        m_rv;
  logic [31:0] m_src1;
  logic [31:0] m_src2;
  logic [63:0] sb [$];
  logic [63:0] popped;

  function automatic logic m_fwd(input logic [4:0] a);
    return TB_BYP && write_req && (write_addr == a);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_fwd(a)) return write_data;
    return m_regs[a];
  endfunction

  function automatic logic m_src_pend(input logic [4:0] a);
    return (a != 5'd0) && m_pend[a] && !m_fwd(a);
  endfunction

  function automatic logic m_hazard();
    return read_en && (m_src_pend(rs1_addr) || m_src_pend(rs2_addr));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_pend <= 32'd0;
      m_rv   <= 1'b0;
      sb.delete();
    end else begin
      if (read_en && !m_hazard()) begin
        sb.push_back({m_read(rs1_addr), m_read(rs2_addr)});
        m_rv <= 1'b1;
      end else begin
        m_rv <= 1'b0;
      end
      if (write_req && write_addr != 5'd0) m_regs[write_addr] <= write_data;
      if (flush) begin
        m_pend <= 32'd0;
      end else begin
        for (int i = 1; i < 32; i++) begin
          if (issue_en && issue_rd == i[4:0]) m_pend[i] <= 1'b1;
          else if (write_req && write_addr == i[4:0]) m_pend[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      m_src1 = 32'd0;
      m_src2 = 32'd0;
    end else if (m_rv) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: read_valid expected but scoreboard empty");
      end else begin
        popped = sb.pop_front();
        m_src1 = popped[63:32];
        m_src2 = popped[31:0];
      end
    end
    n_checks++;
    if (hazard !== m_hazard()) begin
      n_fail++;
      $display("FAIL mon_hazard: got %b expected %b at %0t", hazard, m_hazard(), $time);
    end
    n_checks++;
    if (read_valid !== m_rv) begin
      n_fail++;
      $display("FAIL mon_read_valid: got %b expected %b at %0t", read_valid, m_rv, $time);
    end
    n_checks++;
    if (src1_value !== m_src1 || src2_value !== m_src2) begin
      n_fail++;
      $display("FAIL mon_src: got %h/%h expected %h/%h at %0t",
               src1_value, src2_value, m_src1, m_src2, $time);
    end
  end

  task automatic step(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                      input logic re, input logic [4:0] r1, input logic [4:0] r2,
                      input logic ie, input logic [4:0] ird, input logic fl);
    @(posedge clk);
    #1;
    write_req = wr; write_addr = wa; write_data = wd;
    read_en = re; rs1_addr = r1; rs2_addr = r2;
    issue_en = ie; issue_rd = ird; flush = fl;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    write_req = 1'b0; write_addr = 5'd0; write_data = 32'd0;
    read_en = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0;
    issue_en = 1'b0; issue_rd = 5'd0; flush = 1'b0;
    #2;
    n_checks++;
    if (src1_value !== 32'd0 || src2_value !== 32'd0 || read_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%h/%b expected 0/0/0", src1_value, src2_value, read_valid);
    end
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hazard: got %b expected 0", hazard);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL first_read_hazard: got %b expected 0", hazard);
    end
    idle();
    n_checks++;
    if (src1_value !== 32'd0 || src2_value !== 32'd0 || read_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_read: got %h/%h/%b expected 0/0/1", src1_value, src2_value, read_valid);
    end
  endtask

  task automatic test_write_read();
    step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    idle();
    n_checks++;
    if (src1_value !== 32'hDEADBEEF || read_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_x3: got %h/%b expected deadbeef/1", src1_value, read_valid);
    end
    step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    idle();
    n_checks++;
    if (src2_value !== 32'd0 || src1_value !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL read_x0: got %h/%h expected deadbeef/0", src1_value, src2_value);
    end
  endtask

  task automatic test_hazard();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    n_checks++;
    if (hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL hazard_x7: got %b expected 1", hazard);
    end
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    n_checks++;
    if (read_valid !== 1'b0 || src1_value !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL stall_hold: got %h/%b expected deadbeef/0", src1_value, read_valid);
    end
    step(1'b1, 5'd7, 32'h55, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    n_checks++;
    if (hazard !== !TB_BYP) begin
      n_fail++;
      $display("FAIL hazard_on_wb: got %b expected %b", hazard, !TB_BYP);
    end
    if (!TB_BYP) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
      n_checks++;
      if (hazard !== 1'b0 || read_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL extra_stall: got hz=%b rv=%b expected 0/0", hazard, read_valid);
      end
    end
    idle();
    n_checks++;
    if (src1_value !== 32'h55 || read_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_x7: got %h/%b expected 00000055/1", src1_value, read_valid);
    end
  endtask

  task automatic test_issue_write_same();
    step(1'b1, 5'd9, 32'hA, 1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
    n_checks++;
    if (hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_pending: got %b expected 1", hazard);
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL x9_after_flush: got %b expected 0", hazard);
    end
    idle();
    n_checks++;
    if (src1_value !== 32'hA || read_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_x9: got %h/%b expected 0000000a/1", src1_value, read_valid);
    end
  endtask

  task automatic test_flush();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd6, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd8, 1'b0, 5'd0, 1'b0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_x4_x8: got %b expected 0", hazard);
    end
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd8, 1'b0, 5'd0, 1'b0);
    n_checks++;
    if (hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_x6: got %b expected 0", hazard);
    end
    idle();
    n_checks++;
    if (read_valid !== 1'b1 || src1_value !== 32'd0 || src2_value !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_read: got %h/%h/%b expected 0/0/1", src1_value, src2_value, read_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1) == 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom_range(0, 29) == 0);
    end
    repeat (3) idle();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd2, 1'b0, 5'd0, 1'b0);
    idle();
    n_checks++;
    if (read_valid !== 1'b1 || src1_value !== 32'h77 || src2_value !== 32'h77) begin
      n_fail++;
      $display("FAIL pre_reset_read: got %h/%h/%b expected 77/77/1", src1_value, src2_value, read_valid);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (src1_value !== 32'd0 || src2_value !== 32'd0 || read_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %h/%h/%b expected 0/0/0", src1_value, src2_value, read_valid);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0);
    idle();
    n_checks++;
    if (src1_value !== 32'd0 || read_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_x2: got %h/%b expected 0/1", src1_value, read_valid);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hazard();
    test_issue_write_same();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    repeat (2) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
